left_shift_sequencer: RTL and testbench

LEFT_SHIFT_SEQUENCER -- requirements
Module: left_shift_sequencer

---
 rtl/left_shift_sequencer_pkg.sv | 23 ++
 rtl/left_shift_sequencer_step_shifter.sv | 27 ++
 rtl/left_shift_sequencer.sv | 118 +++++++++++
 tb/tb_left_shift_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/left_shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle left-shift sequencer: FSM encoding,
// default per-cycle step limit and flag bit positions.
package left_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int STEP_MAX_DEFAULT = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Width needed to encode a step amount 0..step_max.
  function automatic int step_width(input int step_max);
    return $clog2(step_max + 1);
  endfunction

endpackage

// File: rtl/left_shift_sequencer_step_shifter.sv
// Combinational single-step shifter: shifts acc left by 0..STEP_MAX and
// reports the last bit pushed out of the top.
module step_shifter
  import left_shift_sequencer_pkg::*;
#(
  parameter int N        = 8,
  parameter int STEP_MAX = STEP_MAX_DEFAULT,
  parameter int STW      = step_width(STEP_MAX)
) (
  input  logic [N-1:0]   acc,
  input  logic [STW-1:0] step,
  output logic [N-1:0]   shifted,
  output logic           carry
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; that is what keeps always_comb from inferring a latch.
  always_comb begin
    shifted = acc << step;
    carry   = 1'b0;
    // The carry is acc[N-step]; unrolling keeps every index a constant.
    for (int i = 1; i <= STEP_MAX; i++) begin
      if (step == STW'(i)) carry = acc[N-i];
    end
  end

endmodule

// File: rtl/left_shift_sequencer.sv
// Multi-cycle logical left shifter: consumes up to STEP_MAX bit positions per
// clock and publishes the result with N/Z/V/C flags on entry to DONE.
module left_shift_sequencer
  import left_shift_sequencer_pkg::*;
#(
  parameter int N        = 8,
  parameter int STEP_MAX = STEP_MAX_DEFAULT,
  parameter int SW       = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] shift,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  out,
  output logic [3:0]    flags_n_z_v_c
);

  localparam int STW = step_width(STEP_MAX);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   acc;
  logic [SW-1:0]  rem;
  logic           msb0;
  logic           v_sticky;

  logic [STW-1:0] step;
  logic [SW-1:0]  rem_next;
  logic [N-1:0]   acc_shifted;
  logic           carry;
  logic           v_step;
  logic           accept;

  step_shifter #(
    .N        (N),
    .STEP_MAX (STEP_MAX),
    .STW      (STW)
  ) u_step_shifter (
    .acc     (acc),
    .step    (step),
    .shifted (acc_shifted),
    .carry   (carry)
  );

  always_comb begin
    if (rem > SW'(STEP_MAX)) step = STW'(STEP_MAX);
    else                     step = STW'(rem);
    rem_next = rem - SW'(step);
    v_step   = v_sticky | (acc_shifted[N-1] ^ msb0);
    accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = (shift == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rem_next == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (accept) state_next = (shift == '0) ? ST_DONE : ST_SHIFT;
        else        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: all registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      rem           <= '0;
      msb0          <= 1'b0;
      v_sticky      <= 1'b0;
      out           <= '0;
      flags_n_z_v_c <= 4'b0000;
    end else if (accept) begin
      acc      <= in_a;
      rem      <= shift;
      msb0     <= in_a[N-1];
      v_sticky <= 1'b0;
      // A zero-distance shift completes immediately with V and C clear.
      if (shift == '0) begin
        out                   <= in_a;
        flags_n_z_v_c[FLAG_N] <= in_a[N-1];
        flags_n_z_v_c[FLAG_Z] <= (in_a == '0);
        flags_n_z_v_c[FLAG_V] <= 1'b0;
        flags_n_z_v_c[FLAG_C] <= 1'b0;
      end
    end else if (state == ST_SHIFT) begin
      acc      <= acc_shifted;
      rem      <= rem_next;
      v_sticky <= v_step;
      if (rem_next == '0) begin
        out                   <= acc_shifted;
        flags_n_z_v_c[FLAG_N] <= acc_shifted[N-1];
        flags_n_z_v_c[FLAG_Z] <= (acc_shifted == '0);
        flags_n_z_v_c[FLAG_V] <= v_step;
        flags_n_z_v_c[FLAG_C] <= carry;
      end
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Scoreboard bench for left_shift_sequencer (N=8, STEP_MAX=4): expected
// results are queued at launch and compared whenever done is observed.
module tb_left_shift_sequencer;

  localparam int N    = 8;
  localparam int SW   = 4;
  localparam int STEP = 4;

  typedef struct packed {
    logic [N-1:0] out;
    logic [3:0]   flags;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  in_a;
  logic [SW-1:0] shift;
  logic          busy;
  logic          done;
  logic [N-1:0]  out;
  logic [3:0]    flags_n_z_v_c;

  int   vectors     = 0;
  int   miscompares = 0;
  res_t sb_q[$];
  res_t last_res;

  always #5 clk = ~clk;

  left_shift_sequencer #(.N(N), .STEP_MAX(STEP), .SW(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_a          (in_a),
    .shift         (shift),
    .busy          (busy),
    .done          (done),
    .out           (out),
    .flags_n_z_v_c (flags_n_z_v_c)
  );

  // Reference: walks bit positions step by step to find the sign changes.
  function automatic res_t model(input logic [N-1:0] a, input int sh);
    res_t r;
    int   remaining;
    int   pos;
    int   st;
    logic v;
    logic c;
    logic msb;
    r.out     = (sh >= N) ? '0 : (a << sh);
    v         = 1'b0;
    pos       = 0;
    remaining = sh;
    while (remaining > 0) begin
      st        = (remaining > STEP) ? STEP : remaining;
      remaining = remaining - st;
      pos       = pos + st;
      msb       = (pos <= N - 1) ? a[N-1-pos] : 1'b0;
      if (msb != a[N-1]) v = 1'b1;
    end
    c       = (sh >= 1 && sh <= N) ? a[N-sh] : 1'b0;
    r.flags = {r.out[N-1], (r.out == '0), v, c};
    return r;
  endfunction

  always @(negedge clk) begin
    res_t got;
    res_t exp;
    if (rst === 1'b0 && done === 1'b1) begin
      vectors++;
      got = {out, flags_n_z_v_c};
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got out=%h flags=%b, none expected", out, flags_n_z_v_c);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL result: got out=%h flags=%b, expected out=%h flags=%b",
                   got.out, got.flags, exp.out, exp.flags);
        end
      end
    end
  end

  task automatic launch(input logic [N-1:0] a, input int sh, output res_t exp);
    exp = model(a, sh);
    sb_q.push_back(exp);
    start = 1'b1;
    in_a  = a;
    shift = SW'(sh);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits up to a bounded number of edges for done; checks latency, busy
  // duration and that the published result holds while working.
  task automatic wait_done(input int m, input res_t exp);
    int c = 0;
    int busy_cycles = 0;
    while (done !== 1'b1 && c < 40) begin
      if (busy === 1'b1) busy_cycles++;
      vectors++;
      if ({out, flags_n_z_v_c} !== last_res) begin
        miscompares++;
        $display("FAIL hold: got out=%h flags=%b, expected out=%h flags=%b",
                 out, flags_n_z_v_c, last_res.out, last_res.flags);
      end
      @(posedge clk); #1;
      c++;
    end
    vectors++;
    if (c !== m) begin
      miscompares++;
      $display("FAIL latency: got %0d edges, expected %0d", c, m);
    end
    vectors++;
    if (busy_cycles !== m) begin
      miscompares++;
      $display("FAIL busy_cycles: got %0d, expected %0d", busy_cycles, m);
    end
    last_res = exp;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input int sh);
    res_t exp;
    launch(a, sh, exp);
    wait_done((sh + STEP - 1) / STEP, exp);
    idle_check();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_a = '0; shift = '0;
    last_res = '0;
    #22;
    vectors++;
    if (out !== '0 || flags_n_z_v_c !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got out=%h flags=%b busy=%b done=%b, expected all 0",
               out, flags_n_z_v_c, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(8'b11110000, 1);
    run_op(8'h81, 0);
    run_op(8'h01, 8);
    run_op(8'h40, 1);
  endtask

  task automatic test_multi_step();
    run_op(8'b11110000, 6);
    run_op(8'hFF, 15);
    run_op(8'h01, 4);
  endtask

  task automatic test_ignore_mid_shift();
    res_t exp;
    launch(8'b11110000, 6, exp);
    start = 1'b1; in_a = 8'hFF; shift = SW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, exp);
  endtask

  task automatic test_back_to_back();
    res_t exp;
    launch(8'h55, 5, exp);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b, expected 1", busy);
    end
    wait_done(2, exp);
    launch(8'h81, 0, exp);
    wait_done(0, exp);
    launch(8'h0F, 3, exp);
    wait_done(1, exp);
    idle_check();
  endtask

  task automatic test_reset_abort();
    res_t exp;
    res_t dropped;
    launch(8'b11110000, 6, exp);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    dropped = sb_q.pop_back();
    last_res = '0;
    vectors++;
    if (out !== '0 || flags_n_z_v_c !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: got out=%h flags=%b busy=%b done=%b, expected all 0 (dropped %h)",
               out, flags_n_z_v_c, busy, done, dropped);
    end
    @(negedge clk);
    rst = 1'b0;
    launch(8'h3C, 2, exp);
    wait_done(1, exp);
    idle_check();
  endtask

  task automatic test_random();
    res_t exp;
    int   sh;
    for (int i = 0; i < 24; i++) begin
      sh = $urandom_range(0, 15);
      launch(N'($urandom), sh, exp);
      wait_done((sh + STEP - 1) / STEP, exp);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_step();
    test_ignore_mid_shift();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending: got %0d results never completed, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
